// File: rtl/image_link_pkg.sv
// Shared image link definitions: FSM encoding, header length and UART
// framing constants used by both the transmit and receive paths.
package image_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX,
    ST_CSUM,
    ST_LAST
  } state_t;

  localparam int   HDR_BYTES = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Header byte order: height MSB, height LSB, width MSB, width LSB.
  function automatic logic [7:0] hdr_byte(
    input logic [31:0] hw,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = hw[31:24];
      2'd1:    b = hw[23:16];
      2'd2:    b = hw[15:8];
      default: b = hw[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: baud counter plus 10-bit shift register.
// ready is high when idle or in the last cycle of the stop bit.
module uart_tx_byte
  import image_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       load,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS + 1);

  logic [DATA_BITS+1:0] shreg;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic                 active;

  assign tx    = shreg[0];
  assign ready = !active ||
                 (bit_cnt == LAST_BIT && baud_cnt == BAUD_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (load && ready) begin
      shreg    <= {STOP_BIT, din, START_BIT};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (baud_cnt == BAUD_MAX) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[DATA_BITS+1:1]};
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt == LAST_BIT) active <= 1'b0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_uart_tx.sv
// Frame transmitter: header + raster pixels over UART 8N1.
// FRAME_TX_CHECKSUM_EN appends a mod-256 sum byte after the pixels.
module frame_uart_tx
  import image_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DIM_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] height,
  input  logic [DIM_W-1:0] width,
  input  logic [7:0]       pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = 2 * DIM_W;
`ifdef FRAME_TX_CHECKSUM_EN
  localparam state_t ST_END = ST_CSUM;
`else
  localparam state_t ST_END = ST_LAST;
`endif

  state_t           state;
  logic [DIM_W-1:0] h_lat;
  logic [DIM_W-1:0] w_lat;
  logic [CNT_W-1:0] tot;
  logic [CNT_W-1:0] pix_cnt;
  logic [1:0]       hdr_idx;
  logic [7:0]       slot;
  logic             slot_full;
  logic             ser_ready;
  logic             load;
  logic             slot_wr;
  logic [7:0]       slot_d;
  logic [7:0]       hb;

  assign pix_ready = (state == ST_PIX) && !slot_full;
  assign load      = slot_full && ser_ready;
  assign hb        = hdr_byte({16'(h_lat), 16'(w_lat)}, hdr_idx);

`ifdef FRAME_TX_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sum <= '0;
    else if (state == ST_IDLE && start)
      sum <= '0;
    else if (slot_wr && state != ST_CSUM)
      sum <= sum + slot_d;
  end
`endif

  always_comb begin
    slot_wr = 1'b0;
    slot_d  = hb;
    unique case (state)
      ST_HDR: slot_wr = !slot_full;
      ST_PIX: begin
        slot_wr = pix_valid && pix_ready;
        slot_d  = pix_data;
      end
`ifdef FRAME_TX_CHECKSUM_EN
      ST_CSUM: begin
        slot_wr = !slot_full;
        slot_d  = sum;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      h_lat     <= '0;
      w_lat     <= '0;
      tot       <= '0;
      pix_cnt   <= '0;
      hdr_idx   <= '0;
      slot      <= '0;
      slot_full <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Slot drains on load; a write below only happens when it was empty.
      if (load) slot_full <= 1'b0;
      if (slot_wr) begin
        slot      <= slot_d;
        slot_full <= 1'b1;
      end
      unique case (state)
        ST_IDLE: if (start) begin
          h_lat   <= height;
          w_lat   <= width;
          tot     <= CNT_W'(height) * CNT_W'(width);
          pix_cnt <= '0;
          hdr_idx <= '0;
          busy    <= 1'b1;
          state   <= ST_HDR;
        end
        ST_HDR: if (slot_wr) begin
          hdr_idx <= hdr_idx + 2'd1;
          if (hdr_idx == 2'(HDR_BYTES - 1))
            state <= (tot == '0) ? ST_END : ST_PIX;
        end
        ST_PIX: if (slot_wr) begin
          if (pix_cnt == tot - CNT_W'(1))
            state <= ST_END;
          else
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
`ifdef FRAME_TX_CHECKSUM_EN
        ST_CSUM: if (slot_wr) state <= ST_LAST;
`endif
        ST_LAST: if (!slot_full && ser_ready) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .reset (reset),
    .din   (slot),
    .load  (load),
    .ready (ser_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx with a UART monitor decoding tx.
// Optional checksum byte is expected when FRAME_TX_CHECKSUM_EN is defined.
module tb_frame_uart_tx;

  localparam int C = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] height;
  logic [15:0] width;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        tx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pix_arr[16];
  int  pix_idx = 0;
  int  pix_n = 0;
  bit  src_en = 0;
  bit  toggle = 0;
  bit  seen_ready = 0;
  bit  xfer = 0;

  logic [9:0] mbits;
  bit mbad;
  bit mabort;

  frame_uart_tx #(
    .CLKS_PER_BIT(C),
    .DIM_W(16)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .height    (height),
    .width     (width),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // UART monitor: every bit must hold for exactly C samples.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        mbad = 0;
        mabort = 0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < C; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst !== 1'b0) mabort = 1;
            if (c == 0) mbits[b] = tx;
            else if (tx !== mbits[b]) mbad = 1;
          end
        end
        if (!mabort) begin
          tests++;
          if (mbad || mbits[0] !== 1'b0 || mbits[9] !== 1'b1) begin
            fails++;
            $display("FAIL uart_frame got bits=%b (start 0, stop 1, %0d-cycle bits required)",
                     mbits, C);
          end
          rx_q.push_back(mbits[8:1]);
        end
      end
    end
  end

  // Pixel source: decides at each negedge whether the next edge transfers.
  initial begin
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (xfer) pix_idx++;
      if (pix_ready === 1'b1) seen_ready = 1;
      pix_valid = src_en && (pix_idx < pix_n) &&
                  (!toggle || ((cyc / 60) % 2 == 0));
      pix_data  = pix_arr[(pix_idx < 16) ? pix_idx : 0];
      xfer      = pix_valid && (pix_ready === 1'b1);
    end
  end

  task automatic build_exp(input logic [15:0] h, input logic [15:0] w);
    logic [7:0] s;
    exp_q.push_back(h[15:8]);
    exp_q.push_back(h[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    s = h[15:8] + h[7:0] + w[15:8] + w[7:0];
    for (int i = 0; i < int'(h) * int'(w); i++) begin
      exp_q.push_back(pix_arr[i]);
      s = s + pix_arr[i];
    end
`ifdef FRAME_TX_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic kick(input logic [15:0] h, input logic [15:0] w);
    @(negedge clk);
    rx_q.delete();
    pix_idx = 0;
    height = h;
    width = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    height = '0;
    width = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL rst_tx got %b exp 1", tx); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
    tests++;
    if (pix_ready !== 1'b0) begin
      fails++; $display("FAIL rst_pix_ready got %b exp 0", pix_ready);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int n, d0;
    for (int i = 0; i < 6; i++) pix_arr[i] = 8'h10 + 8'(i);
    pix_n = 6; src_en = 1; toggle = 0;
    exp_q.delete();
    build_exp(16'd2, 16'd3);
    d0 = done_cnt;
    kick(16'd2, 16'd3);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy); end
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL basic_tx_k got %b exp 1", tx); end
    @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL basic_tx_k1 got %b exp 1", tx); end
    @(negedge clk);
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL basic_tx_k2 got %b exp 0", tx); end
    wait_done(2000, n);
    tests++;
    if (n != 10 * C * exp_q.size()) begin
      fails++; $display("FAIL basic_done_time got %0d exp %0d", n, 10 * C * exp_q.size());
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b exp 0", done); end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt - d0);
    end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_nbytes got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_byte%0d got %h exp %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero;
    int n;
    for (int i = 0; i < 5; i++) pix_arr[i] = 8'hE0 + 8'(i);
    pix_n = 5; src_en = 1; toggle = 0;
    exp_q.delete();
    build_exp(16'd0, 16'd5);
    seen_ready = 0;
    kick(16'd0, 16'd5);
    wait_done(2000, n);
    tests++;
    if (n != 2 + 10 * C * exp_q.size()) begin
      fails++; $display("FAIL zero_done_time got %0d exp %0d", n, 2 + 10 * C * exp_q.size());
    end
    repeat (3) @(negedge clk);
    tests++;
    if (seen_ready != 0) begin fails++; $display("FAIL zero_pix_ready got 1 exp 0"); end
    tests++;
    if (pix_idx != 0) begin fails++; $display("FAIL zero_accepted got %0d exp 0", pix_idx); end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL zero_nbytes got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL zero_byte%0d got %h exp %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall;
    int n;
    pix_arr[0] = 8'hA5; pix_arr[1] = 8'h3C;
    pix_arr[2] = 8'hFF; pix_arr[3] = 8'h00;
    pix_n = 4; src_en = 1; toggle = 1;
    exp_q.delete();
    build_exp(16'd1, 16'd4);
    kick(16'd1, 16'd4);
    wait_done(4000, n);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL stall_done got %b exp 1", done); end
    tests++;
    if (n <= 2 + 10 * C * exp_q.size()) begin
      fails++; $display("FAIL stall_gap got %0d cycles exp > %0d", n, 2 + 10 * C * exp_q.size());
    end
    toggle = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stall_nbytes got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stall_byte%0d got %h exp %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n, d0;
    for (int i = 0; i < 6; i++) pix_arr[i] = 8'h10 + 8'(i);
    pix_n = 6; src_en = 1; toggle = 0;
    kick(16'd2, 16'd3);
    // 260 cycles in: data bit 3 of pixel 0x12, which is 0
    repeat (260) @(negedge clk);
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL rmid_tx_before got %b exp 0", tx); end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL rmid_tx got %b exp 1", tx); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
    tests++;
    if (pix_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_pix_ready got %b exp 0", pix_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    tests++;
    if (done_cnt != d0) begin
      fails++; $display("FAIL rmid_no_done got %0d pulses exp 0", done_cnt - d0);
    end
    exp_q.delete();
    build_exp(16'd2, 16'd3);
    kick(16'd2, 16'd3);
    wait_done(2000, n);
    tests++;
    if (n != 2 + 10 * C * exp_q.size()) begin
      fails++; $display("FAIL rmid_done_time got %0d exp %0d", n, 2 + 10 * C * exp_q.size());
    end
    repeat (3) @(negedge clk);
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rmid_nbytes got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rmid_byte%0d got %h exp %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore;
    int n, d0;
    pix_arr[0] = 8'h21; pix_arr[1] = 8'h22; pix_arr[2] = 8'h23;
    pix_n = 3; src_en = 1; toggle = 0;
    exp_q.delete();
    build_exp(16'd1, 16'd3);
    d0 = done_cnt;
    kick(16'd1, 16'd3);
    repeat (100) @(negedge clk);
    height = 16'd7;
    width = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, n);
    tests++;
    if (101 + n != 2 + 10 * C * exp_q.size()) begin
      fails++;
      $display("FAIL ign_done_time got %0d exp %0d", 101 + n, 2 + 10 * C * exp_q.size());
    end
    repeat (600) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt - d0);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ign_busy got %b exp 0", busy); end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ign_nbytes got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ign_byte%0d got %h exp %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, d0;
    pix_n = 0; src_en = 0;
    exp_q.delete();
    build_exp(16'd0, 16'd1);
    build_exp(16'd0, 16'd1);
    d0 = done_cnt;
    @(negedge clk);
    rx_q.delete();
    height = 16'd0;
    width = 16'd1;
    start = 1'b1;
    wait_done(2000, n);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b exp 1", done); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_restart got %b exp 1", busy); end
    start = 1'b0;
    wait_done(2000, n);
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 2) begin
      fails++; $display("FAIL b2b_done_cnt got %0d exp 2", done_cnt - d0);
    end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_nbytes got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d got %h exp %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_stall;
    test_reset_mid;
    test_ignore;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
